// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: walks a fixed codec register-write table through an I2C master after reset,
// retrying NACKed or timed-out writes and flagging init_done or init_error.
module codec_init_sequencer #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int NUM_REGS = 11,
  parameter int STARTUP_CYCLES = 1000,
  parameter int GAP_CYCLES = 200,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_we,
  input  logic [1:0] i2c_status,
  output logic [8:0] device_address,
  output logic [7:0] reg_address,
  output logic [7:0] data_out,
  output logic [3:0] index,
  output logic       init_done,
  output logic       init_error
);
  localparam int CMAX = STARTUP_CYCLES > TIMEOUT_CYCLES
    ? (STARTUP_CYCLES > GAP_CYCLES ? STARTUP_CYCLES : GAP_CYCLES)
    : (TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES);
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {STARTUP, LOAD, REQ, WAIT, RETRYCHK, GAP, DONE, ERROR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [4:0] idx;
  logic req;
  logic [15:0] word;
  assign device_address = {req, DEV_ADDR, 1'b0};
  assign index = idx[3:0];
  always_comb begin
    word = 16'h0000;
    case (idx)
      5'd0: word = 16'h1E00;
      5'd1: word = 16'h0017;
      5'd2: word = 16'h0217;
      5'd3: word = 16'h0479;
      5'd4: word = 16'h0679;
      5'd5: word = 16'h0812;
      5'd6: word = 16'h0A00;
      5'd7: word = 16'h0C00;
      5'd8: word = 16'h0E02;
      5'd9: word = 16'h1000;
      5'd10: word = 16'h1201;
      default: word = 16'h0000;
    endcase
  end
  // one shared counter: free-runs by default and is cleared on every state change
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STARTUP;
      cnt <= '0;
      retry <= '0;
      idx <= '0;
      req <= 1'b0;
      reg_address <= '0;
      data_out <= '0;
      init_done <= 1'b0;
      init_error <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        STARTUP: if (cnt == CW'(STARTUP_CYCLES)) begin
          state <= LOAD;
          cnt <= '0;
        end
        LOAD: begin
          reg_address <= word[15:8];
          data_out <= word[7:0];
          req <= 1'b1;
          state <= REQ;
          cnt <= '0;
        end
        REQ: if (i2c_status[0]) begin
          req <= 1'b0;
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: if (i2c_we) begin
          cnt <= '0;
          if (i2c_status[1]) state <= RETRYCHK;
          else begin
            idx <= idx + 5'd1;
            retry <= '0;
            state <= GAP;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state <= RETRYCHK;
          cnt <= '0;
        end
        RETRYCHK: begin
          cnt <= '0;
          if (retry < RW'(MAX_RETRY)) begin
            retry <= retry + 1'b1;
            state <= GAP;
          end else begin
            init_error <= 1'b1;
            state <= ERROR;
          end
        end
        GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt <= '0;
          if (idx == 5'(NUM_REGS)) begin
            init_done <= 1'b1;
            state <= DONE;
          end else state <= LOAD;
        end
        DONE, ERROR: begin
          cnt <= '0;
          if (start) begin
            idx <= '0;
            retry <= '0;
            init_done <= 1'b0;
            init_error <= 1'b0;
            state <= LOAD;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb_codec_init_sequencer: fault-plan table plus randomized plans against an attempt-level bus model.
module tb_codec_init_sequencer;
  localparam int S = 1000, GAP = 200, T = 4095, MAXR = 3, NUM = 11;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, i2c_we = 1'b0;
  logic [1:0] i2c_status = 2'b00;
  logic [8:0] device_address;
  logic [7:0] reg_address, data_out;
  logic [3:0] index;
  logic init_done, init_error;
  int n_vec = 0, n_bad = 0;
  int plan[16];
  bit plan_hang;
  int abort_at;
  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                            16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

  codec_init_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .i2c_we(i2c_we), .i2c_status(i2c_status),
    .device_address(device_address), .reg_address(reg_address), .data_out(data_out),
    .index(index), .init_done(init_done), .init_error(init_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; i2c_we = 1'b0; i2c_status = 2'b00;
    @(negedge clock);
    @(negedge clock);
    chk("rst_device_address", device_address, 9'h034);
    chk("rst_reg_address", reg_address, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_index", index, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_init_error", init_error, 0);
    reset = 1'b0;
  endtask

  // waits for the request line, sprinkling ignored i2c_we pulses when no transaction is pending
  task automatic wait_req(output int c);
    for (c = 1; c <= 20000; c++) begin
      i2c_we = !plan_hang && ($urandom_range(0, 15) == 0);
      i2c_status = {1'($urandom_range(0, 1)), 1'b0};
      @(negedge clock);
      if (device_address[8]) begin
        i2c_we = 1'b0; i2c_status = 2'b00;
        return;
      end
    end
    i2c_we = 1'b0; i2c_status = 2'b00;
    chk("req_timeout", device_address[8], 1);
    c = -1;
  endtask

  // reference outcome: entry e takes plan[e]+1 attempts unless plan[e] exceeds the retry budget
  function automatic void model(output bit d, output int idx, output int n);
    d = 1'b1; idx = NUM; n = 0;
    for (int e = 0; e < NUM; e++) begin
      if (plan[e] > MAXR) begin
        n += MAXR + 1; d = 1'b0; idx = e;
        return;
      end
      n += plan[e] + 1;
    end
  endfunction

  task automatic run_plan(input bit do_rst, output int n, output bit d, output bit err, output int idx);
    int q[$];
    int tries[16];
    int c, exp_c, nb, e, k;
    bit fail_now;
    n = 0; d = 1'b0; err = 1'b0; idx = -1; fail_now = 1'b0;
    for (int i = 0; i < 16; i++) tries[i] = 0;
    for (int i = 0; i < NUM; i++) begin
      k = plan[i] > MAXR ? MAXR + 1 : plan[i] + 1;
      repeat (k) q.push_back(i);
      if (plan[i] > MAXR) break;
    end
    if (do_rst) begin
      apply_reset();
      exp_c = S + 2;
    end else begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      exp_c = 1;
    end
    for (int j = 0; j < q.size(); j++) begin
      e = q[j];
      wait_req(c);
      if (c < 0) return;
      chk("req_latency", c, exp_c);
      n++;
      chk("index", index, e);
      chk("reg_address", reg_address, tbl[e][15:8]);
      chk("data_out", data_out, tbl[e][7:0]);
      chk("dev_addr", device_address[7:0], 8'h34);
      fail_now = tries[e] < plan[e];
      tries[e]++;
      i2c_status = 2'b01;
      @(negedge clock);
      chk("req_drop", device_address[8], 0);
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) begin
        start = ($urandom_range(0, 3) == 0);
        @(negedge clock);
        start = 1'b0;
      end
      chk("payload_hold", {reg_address, data_out}, tbl[e]);
      if (e == abort_at) begin
        reset = 1'b1; i2c_status = 2'b00;
        @(negedge clock);
        chk("abort_device_address", device_address, 9'h034);
        chk("abort_payload", {reg_address, data_out}, 0);
        d = init_done; err = init_error; idx = index;
        return;
      end
      if (fail_now && plan_hang) begin
        i2c_status = 2'b00;
        exp_c = T + GAP + 2 - nb;
      end else begin
        i2c_we = 1'b1; i2c_status = {fail_now, 1'b1};
        @(negedge clock);
        i2c_we = 1'b0; i2c_status = 2'b00;
        exp_c = fail_now ? GAP + 2 : GAP + 1;
      end
    end
    if (!fail_now) begin
      repeat (GAP - 1) @(negedge clock);
      chk("done_early", init_done, 0);
      @(negedge clock);
      chk("done_rise", init_done, 1);
    end else begin
      k = 0;
      while (!init_error && k < T + 50) begin
        @(negedge clock);
        k++;
      end
    end
    d = init_done; err = init_error; idx = index;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      i2c_we = ($urandom_range(0, 7) == 0);
      i2c_status = {1'($urandom_range(0, 1)), 1'b0};
      @(negedge clock);
      if (device_address[8]) k++;
    end
    i2c_we = 1'b0; i2c_status = 2'b00;
    chk("quiet_after_end", k, 0);
  endtask

  typedef struct {
    bit rst; int abort_at; int bad; int nacks; bit hang;
    bit exp_done; bit exp_err; int exp_idx; int exp_n;
  } vec_t;
  vec_t vt[8];

  initial begin
    int n, idx, mi, mn;
    bit d, err, md;
    vt[0] = '{1'b1, -1, -1,  0, 1'b0, 1'b1, 1'b0, 11, 11};
    vt[1] = '{1'b0, -1,  3,  2, 1'b0, 1'b1, 1'b0, 11, 13};
    vt[2] = '{1'b1, -1,  5, 99, 1'b0, 1'b0, 1'b1,  5,  9};
    vt[3] = '{1'b0, -1, 10,  3, 1'b0, 1'b1, 1'b0, 11, 14};
    vt[4] = '{1'b1, -1,  0, 99, 1'b1, 1'b0, 1'b1,  0,  4};
    vt[5] = '{1'b1, -1,  7,  1, 1'b1, 1'b1, 1'b0, 11, 12};
    vt[6] = '{1'b1,  7, -1,  0, 1'b0, 1'b0, 1'b0,  0,  8};
    vt[7] = '{1'b1, -1, -1,  0, 1'b0, 1'b1, 1'b0, 11, 11};
    for (int v = 0; v < 8; v++) begin
      for (int e = 0; e < 16; e++) plan[e] = 0;
      if (vt[v].bad >= 0) plan[vt[v].bad] = vt[v].nacks;
      plan_hang = vt[v].hang;
      abort_at = vt[v].abort_at;
      run_plan(vt[v].rst, n, d, err, idx);
      chk($sformatf("v%0d_attempts", v), n, vt[v].exp_n);
      chk($sformatf("v%0d_init_done", v), d, vt[v].exp_done);
      chk($sformatf("v%0d_init_error", v), err, vt[v].exp_err);
      chk($sformatf("v%0d_index", v), idx, vt[v].exp_idx);
    end
    for (int r = 0; r < 2; r++) begin
      for (int e = 0; e < 16; e++) plan[e] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
      plan_hang = 1'b0;
      abort_at = -1;
      model(md, mi, mn);
      run_plan(1'b1, n, d, err, idx);
      chk($sformatf("rnd%0d_attempts", r), n, mn);
      chk($sformatf("rnd%0d_init_done", r), d, md);
      chk($sformatf("rnd%0d_init_error", r), err, !md);
      chk($sformatf("rnd%0d_index", r), idx, mi);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
